// File: rtl/cmd_queue_pkg.sv
// rtl/cmd_queue_pkg.sv - shared types and default parameters for the command queue
package cmd_queue_pkg;

  // Controller activity: idle until a command is accepted, active until drained and finished
  typedef enum logic {
    CQ_IDLE   = 1'b0,
    CQ_ACTIVE = 1'b1
  } cq_state_t;

  localparam int CQ_WIDTH   = 64;
  localparam int CQ_DEPTH   = 8;
  localparam int CQ_NUM_SRC = 2;
  localparam int CQ_MAX_OUT = 15;

  // One command word, shared by the top level and benches
  typedef logic [CQ_WIDTH-1:0] cmd_t;

endpackage

// File: rtl/cmd_queue_ctrl_rr_arbiter.sv
// rtl/cmd_queue_ctrl_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] w_s;

  // Scan from farthest to nearest so the requester closest to rr (upward, wrapping) wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_s     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_s = IW'((int'(rr) + k) % N);
      if (req[w_s]) begin
        gnt      = '0;
        gnt[w_s] = 1'b1;
        gnt_idx  = w_s;
      end
    end
  end

endmodule

// File: rtl/cmd_queue_ctrl.sv
// rtl/cmd_queue_ctrl.sv - multi-source command FIFO with outstanding tracking and completion pulse
module cmd_queue_ctrl
  import cmd_queue_pkg::*;
#(
  parameter int WIDTH   = $bits(cmd_t),
  parameter int DEPTH   = CQ_DEPTH,
  parameter int NUM_SRC = CQ_NUM_SRC,
  parameter int MAX_OUT = CQ_MAX_OUT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic [NUM_SRC-1:0]         i_wr_valid,
  input  logic [NUM_SRC*WIDTH-1:0]   i_wr_data,
  output logic [NUM_SRC-1:0]         o_wr_ready,
  input  logic                       i_read,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  input  logic                       i_task_done,
  output logic [$clog2(MAX_OUT+1)-1:0] o_outstanding,
  output logic                       o_done,
  output logic                       o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count, w_count_nxt;
  logic               r_empty, r_full;
  logic [OW-1:0]      r_out, w_out_nxt;
  logic               r_err, r_done, w_done_nxt;
  logic [RW-1:0]      r_rr, w_gnt_idx;
  logic [NUM_SRC-1:0] w_gnt;
  logic               w_can_accept, w_wr, w_rd, w_rd_err, w_out_err;
  logic [WIDTH-1:0]   w_wr_data;
  cq_state_t          r_state, w_state_nxt;

  rr_arbiter #(.N(NUM_SRC), .IW(RW)) u_arb (
    .req     (i_wr_valid),
    .rr      (r_rr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // A full buffer can still take a write when the head is popped in the same cycle
  assign w_can_accept = !i_rst && !i_flush && (!r_full || i_read);
  assign o_wr_ready   = w_can_accept ? w_gnt : '0;
  assign w_wr         = |o_wr_ready;
  assign w_wr_data    = i_wr_data[w_gnt_idx*WIDTH +: WIDTH];
  assign w_rd         = i_read && !r_empty && !i_flush;
  assign w_rd_err     = i_read && r_empty && !i_flush;

  // Occupancy after this cycle's flush / push / pop
  always_comb begin
    w_count_nxt = r_count;
    if (i_flush)
      w_count_nxt = '0;
    else if (w_wr && !w_rd)
      w_count_nxt = r_count + CW'(1);
    else if (!w_wr && w_rd)
      w_count_nxt = r_count - CW'(1);
  end

  // Issued-minus-finished with saturation at both ends; hitting a limit flags an error
  always_comb begin
    w_out_nxt = r_out;
    w_out_err = 1'b0;
    if (w_rd && !i_task_done) begin
      if (r_out == OW'(MAX_OUT)) w_out_err = 1'b1;
      else                       w_out_nxt = r_out + OW'(1);
    end else if (!w_rd && i_task_done) begin
      if (r_out == '0) w_out_err = 1'b1;
      else             w_out_nxt = r_out - OW'(1);
    end
  end

  // Pointers, occupancy flags, outstanding counter, sticky error and arbiter pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_out    <= '0;
      r_err    <= 1'b0;
      r_rr     <= '0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_out   <= w_out_nxt;
      r_err   <= r_err | w_rd_err | w_out_err;
      if (w_wr)
        r_rr <= (w_gnt_idx == RW'(NUM_SRC - 1)) ? '0 : w_gnt_idx + RW'(1);
    end
  end

  // Command storage; contents need no reset because o_data is masked while empty
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wr_data;
  end

  // State register and registered completion pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CQ_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Leave ACTIVE only once both the buffer and the outstanding count reach zero
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      CQ_IDLE:   if (w_wr) w_state_nxt = CQ_ACTIVE;
      CQ_ACTIVE: if (w_count_nxt == '0 && w_out_nxt == '0) begin
                   w_state_nxt = CQ_IDLE;
                   w_done_nxt  = 1'b1;
                 end
      default:   w_state_nxt = CQ_IDLE;
    endcase
  end

  assign o_data        = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_count       = r_count;
  assign o_outstanding = r_out;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: doc/cmd_queue_ctrl.md
# cmd_queue_ctrl

Parametrised command queue between command producers and the issuer in `top`. It replaces the preloaded single-port FIFO with a multi-source write side, using round-robin arbitration of up to NUM_SRC producers into one circular buffer. It presents a first-word-fall-through read port to the issuer. It tracks issued-but-unfinished commands and pulses a completion flag when the queue drains and all issued commands have finished.

## Interface
- WIDTH, 64: command width in bits; equals `$bits(cmd_t)` at instantiation.
- DEPTH, 8: buffer entries; power of two, ≥2.
- NUM_SRC, 2: number of write sources, ≥1.
- MAX_OUT, 15: maximum outstanding issued commands; sets the width of `o_outstanding`.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_flush  in  1  discard all buffered commands.
- i_wr_valid  in  NUM_SRC  per-source write request.
- i_wr_data  in  NUM_SRC×WIDTH  per-source command.
- o_wr_ready  out  NUM_SRC  per-source accept; at most one bit high.
- i_read  in  1  issuer pops the head.
- o_data  out  WIDTH  head entry; valid whenever `o_empty`=0.
- o_empty  out  1  buffer empty.
- o_full  out  1  buffer full.
- o_count  out  $clog2(DEPTH+1)  occupied entries.
- i_task_done  in  1  one-cycle pulse per finished command.
- o_outstanding  out  $clog2(MAX_OUT+1)  issued minus finished.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky protocol error.

## Operation
- **Arbiter.** A round-robin pointer `rr` starts at 0. The grant goes to the first source with `i_wr_valid` set, searching from `rr` upward with wrap.
  - `o_wr_ready[g]`=1 only if the FIFO can accept this cycle: not full, or full with `i_read` asserted. It is also 0 during flush or reset.
  - On an accepted write, `rr` ← g+1 mod NUM_SRC. Otherwise `rr` holds.
  - `o_wr_ready` is combinational from `i_wr_valid`. A source must not make `i_wr_valid` depend on `o_wr_ready`.
- **Buffer.** Read and write pointers are $clog2(DEPTH) bits and wrap naturally. `o_count` is kept as a separate register.
  - A read on an empty buffer is ignored and sets `o_err`.
  - Simultaneous read and write when full: both happen, and count is unchanged.
  - Simultaneous read and write when empty: only the write happens, and `o_err` is set.
- **Flush.** Pointers and count go to 0 next cycle. Writes and reads that cycle are dropped. Outstanding and `o_err` are untouched.
- **Outstanding counter.** +1 on an effective read, −1 on `i_task_done`, unchanged when both occur in the same cycle.
  - `i_task_done` at 0 outstanding sets `o_err`; the counter saturates at 0.
  - Reads at MAX_OUT are not blocked. They set `o_err` and the counter saturates.
- **FSM.** IDLE → ACTIVE on any accepted write. ACTIVE → IDLE when next-state count=0 and next-state outstanding=0. `o_done` pulses on the ACTIVE→IDLE transition.

## Timing
- Reset values: `o_wr_ready`=0, `o_empty`=1, `o_full`=0, `o_count`=0, `o_outstanding`=0, `o_done`=0, `o_err`=0, `o_data`=0, `rr`=0, state=IDLE.
- Write to visibility: write accepted at edge N, so `o_empty`=0 and `o_data` is valid after edge N (same-cycle visibility is not permitted).
- `o_data` is read from the buffer at the read pointer. It changes the cycle after a pop.
- `o_done` is registered and is high for the cycle after the transition edge.
- `o_full`, `o_empty` and `o_count` are registered and update coherently.
- Reset in mid-operation overrides flush, writes and reads. All state returns to its reset value next cycle, and no `o_done` pulse is produced.

## Structure
- `cmd_queue_pkg` holds:
  - the state enum `cq_state_t {CQ_IDLE, CQ_ACTIVE}`;
  - default parameter constants;
  - the `cmd_t` import, so `top` and benches share one command width.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `rr`; outputs one-hot `gnt` and `gnt_idx`. It is purely combinational and reusable by the pool issuer.
- The buffer, counters and FSM are inline in `cmd_queue_ctrl`.

## Test plan
- **Round-robin fairness.** NUM_SRC=2, both sources hold valid continuously with `i_read` idle, and writes start from reset. Required: grants go 0,1,0,1, … until `o_full`=1 after 8 accepts; then `o_wr_ready`=0, and `o_count`=8.
- **Full with simultaneous read/write.** In the full state, pulse `i_read` with source 1 valid. Required: the head pops, the write is accepted, `o_count` stays 8, and the wrap-around order is preserved over 3 full buffer rotations.
- **Drain and completion.** Write 3 commands, pop all 3, then pulse `i_task_done` 3 times. Required: `o_outstanding` goes 1,2,3 then 2,1,0. `o_done` is high for exactly one cycle, after the third done pulse.
- **Error conditions.**
  - Pop when empty: required `o_err`=1 and count stays 0.
  - Separately, after reset, pulse `i_task_done` with 0 outstanding: required `o_err`=1 and `o_outstanding` stays 0.
- **Flush.** Flush with 5 entries and 2 outstanding. Required: `o_empty`=1 and `o_count`=0 next cycle, `o_outstanding`=2, and no `o_done` pulse until two `i_task_done` pulses have arrived.
- **Mid-operation reset.** Assert `i_rst` during a write and read burst. Required: all outputs at reset values on the next cycle, with no `o_done` pulse.
